// File: rtl/decim_scan_if.sv
// Handshake and RAM-port bundle between the decimation scan sequencer and its host/RAMs.
interface decim_scan_if #(
  parameter int ADDR_W = 15
);
  logic              start;
  logic [2:0]        escala;
  logic [ADDR_W-1:0] src_addr;
  logic              src_rd;
  logic [7:0]        src_data;
  logic [ADDR_W-1:0] dst_addr;
  logic [7:0]        dst_data;
  logic              dst_we;
  logic              busy;
  logic              done;
  logic              error;
  logic [9:0]        out_w;
  logic [9:0]        out_h;

  modport master (
    input  start, escala, src_data,
    output src_addr, src_rd, dst_addr, dst_data, dst_we, busy, done, error, out_w, out_h
  );

  modport slave (
    output start, escala, src_data,
    input  src_addr, src_rd, dst_addr, dst_data, dst_we, busy, done, error, out_w, out_h
  );
endinterface

// File: rtl/decim_scan_ctrl.sv
// Decimation scan sequencer: walks kept source pixels in raster order with step
// counters and copies each one to a linearly addressed destination buffer.
//
// state | meaning
// IDLE  | waiting for start; escala=0 on start raises error
// RD    | source read of pixel (x,y) at row_base+x
// WR    | destination write of returned data, advance x/y
// DONE  | one-cycle completion pulse
module decim_scan_ctrl #(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic         clk,
  input  logic         rst,
  decim_scan_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        esc_q;
  logic [9:0]        x_q, y_q;
  logic [ADDR_W-1:0] row_base_q, step_q, dst_cnt_q, dst_addr_q;
  logic [9:0]        out_w_q, out_h_q;
  logic              error_q;

  logic [9:0]        w_calc, h_calc;
  logic [ADDR_W-1:0] step_calc;
  logic [10:0]       x_sum, y_sum;
  logic              x_more, y_more, accept;

  logic              src_rd, dst_we, busy, done;
  logic [7:0]        dst_data;
  logic [ADDR_W-1:0] dst_addr;

  function automatic logic [9:0] ceil_div(input int n, input int k);
    return 10'((n + k - 1) / k);
  endfunction

  // Every legal factor has its dimensions and row step folded to constants.
  always_comb begin
    w_calc    = '0;
    h_calc    = '0;
    step_calc = '0;
    for (int k = 1; k < 8; k++) begin
      if (bus.escala == 3'(k)) begin
        w_calc    = ceil_div(SRC_W, k);
        h_calc    = ceil_div(SRC_H, k);
        step_calc = ADDR_W'(k * SRC_W);
      end
    end
  end

  assign x_sum  = {1'b0, x_q} + {8'd0, esc_q};
  assign y_sum  = {1'b0, y_q} + {8'd0, esc_q};
  assign x_more = x_sum < 11'(SRC_W);
  assign y_more = y_sum < 11'(SRC_H);
  assign accept = (state_q == IDLE) && bus.start && (bus.escala != 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    src_rd   = 1'b0;
    dst_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    dst_data = 8'd0;
    dst_addr = dst_addr_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RD;
      RD: begin
        src_rd  = 1'b1;
        busy    = 1'b1;
        state_d = WR;
      end
      WR: begin
        dst_we   = 1'b1;
        busy     = 1'b1;
        dst_data = bus.src_data;
        dst_addr = dst_cnt_q;
        state_d  = (x_more || y_more) ? RD : DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      esc_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      step_q     <= '0;
      dst_cnt_q  <= '0;
      dst_addr_q <= '0;
      out_w_q    <= '0;
      out_h_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      error_q <= (state_q == IDLE) && bus.start && (bus.escala == 3'd0);
      if (accept) begin
        esc_q      <= bus.escala;
        x_q        <= '0;
        y_q        <= '0;
        row_base_q <= '0;
        dst_cnt_q  <= '0;
        step_q     <= step_calc;
        out_w_q    <= w_calc;
        out_h_q    <= h_calc;
      end
      if (state_q == WR) begin
        dst_addr_q <= dst_cnt_q;
        dst_cnt_q  <= dst_cnt_q + 1'b1;
        if (x_more) begin
          x_q <= x_sum[9:0];
        end else if (y_more) begin
          x_q        <= '0;
          y_q        <= y_sum[9:0];
          row_base_q <= row_base_q + step_q;
        end
      end
    end
  end

  // x and row_base are frozen outside WR, so the read address holds its last value.
  assign bus.src_addr = row_base_q + ADDR_W'(x_q);
  assign bus.src_rd   = src_rd;
  assign bus.dst_addr = dst_addr;
  assign bus.dst_data = dst_data;
  assign bus.dst_we   = dst_we;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.error    = error_q;
  assign bus.out_w    = out_w_q;
  assign bus.out_h    = out_h_q;

endmodule

// File: doc/decim_scan_ctrl.md
# decim_scan_ctrl

Sequencer for the decimation path of the image coprocessor. On `start` it walks the source frame buffer in raster order, visiting only the coordinates kept by the scale factor (x and y both multiples of `escala`). For each kept pixel it issues a read to source RAM and then a write to destination RAM at a linearly incrementing address. It replaces per-pixel modulo tests with step counters, so no pixel that would be discarded is ever read. It also reports the output frame dimensions.

## Interface
Parameters:
- `SRC_W`, default 160: source width in pixels (2..1023).
- `SRC_H`, default 120: source height in pixels (2..1023).
- `ADDR_W`, default 15: address width for both RAMs; must satisfy 2^ADDR_W ≥ SRC_W*SRC_H.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request to begin a decimation pass; sampled only in IDLE.
- `escala`  in  3  decimation factor 1..7, latched on accepted `start`; 0 is illegal.
- `src_addr`  out  ADDR_W  source RAM read address.
- `src_rd`  out  1  source read strobe.
- `src_data`  in  8  source RAM data, valid the cycle after `src_rd` (synchronous read).
- `dst_addr`  out  ADDR_W  destination RAM write address.
- `dst_data`  out  8  destination write data, combinationally equal to `src_data` in WR.
- `dst_we`  out  1  destination write enable.
- `busy`  out  1  pass in progress.
- `done`  out  1  one-cycle pulse when a pass completes.
- `error`  out  1  one-cycle pulse when `start` arrives with `escala` = 0.
- `out_w`  out  10  output width, ceil(SRC_W/escala); valid from the first RD cycle.
- `out_h`  out  10  output height, ceil(SRC_H/escala); valid from the first RD cycle.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE, `start`=1, `escala`≠0:
  - Latch `esc`; clear x, y, row_base (source address of row y) and dst counter.
  - Load `out_w`/`out_h`, computed by repeated-add counters or constant division; no `%` in the RTL.
  - Go to RD.
- IDLE, `start`=1, `escala`=0: pulse `error` for 1 cycle; stay in IDLE; no RAM access.
- RD:
  - `src_rd`=1 and `src_addr`=row_base+x.
  - Go to WR.
- WR:
  - `dst_we`=1, `dst_addr`=dst counter, `dst_data`=`src_data`.
  - Dst counter +1.
  - If x+esc < SRC_W: x += esc, go to RD.
  - Else if y+esc < SRC_H: x=0, y += esc, row_base += esc*SRC_W (use a precomputed step register; no runtime multiply), go to RD.
  - Else go to DONE.
- DONE: `done`=1 for 1 cycle, then IDLE.
- Arithmetic:
  - x and y are 10 bits; compare x+esc as 11 bits so the sum cannot wrap.
  - row_base and the dst counter are ADDR_W bits.
  - The final dst counter value equals out_w*out_h.
- `start` in any state other than IDLE is ignored. A change in `escala` mid-pass has no effect.
- Outputs outside the active state: `src_rd`, `dst_we`, `done` and `error` are 0 outside RD, WR, DONE and the error cycle respectively. `src_addr`/`dst_addr` hold their last value.
- `busy`=1 in RD and WR only.

## Timing
- Reset values: state IDLE. All outputs are 0: `src_addr`, `src_rd`, `dst_addr`, `dst_we`, `busy`, `done`, `error`, `out_w`, `out_h`. The internal x, y, row_base and dst counter are also 0.
- `rst` mid-pass: immediate return to IDLE. No further `src_rd`/`dst_we`. A partially written destination is left as is.
- Latency: let N = out_w*out_h and let `start` be sampled at edge 0.
  - RD at cycles 1,3,…,2N-1.
  - WR at cycles 2,4,…,2N.
  - `done` at cycle 2N+1.
  - IDLE at cycle 2N+2; a new `start` can be accepted there.
- Throughput: one output pixel per 2 cycles; no bubbles at row wrap.
- `escala`=1 is a full copy: N = SRC_W*SRC_H, and `src_addr` equals `dst_addr` for every pixel.
- If `escala` ≥ SRC_W and ≥ SRC_H, then N=1: a single read and write of pixel (0,0).

## Test plan
Use SRC_W=8, SRC_H=6, with source RAM preloaded so mem[a]=a.
- `escala`=2, `start` pulse:
  - 12 writes, `dst_addr` 0..11.
  - `src_addr` sequence 0,2,4,6,16,18,20,22,32,34,36,38.
  - `dst_data` equals `src_addr`.
  - `out_w`=4, `out_h`=3.
  - `done` at cycle 25.
- `escala`=3:
  - 6 writes, `src_addr` 0,3,6,24,27,30.
  - `out_w`=3, `out_h`=2.
  - `done` at cycle 13.
- `escala`=7:
  - 2 writes, `src_addr` 0,7.
  - `out_w`=2, `out_h`=1.
  - `done` at cycle 5.
- `escala`=0:
  - `error` is high for exactly 1 cycle.
  - `busy`, `src_rd` and `dst_we` stay 0; `done` never pulses.
- Second `start` during a pass with `escala`=2: ignored. Change `escala` to 3 mid-pass: the pass still completes as `escala`=2 (12 writes).
- Assert `rst` after the 5th write:
  - All outputs are 0 on the same cycle; no further `dst_we`.
  - A subsequent `start` with `escala`=1 produces 48 writes, `dst_addr` 0..47, with `done` at cycle 97.
